// File: rtl/mux_pkg.sv
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared mode encodings and width helpers for the mux_nw_sel block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // A select port needs at least one bit even when clog2 collapses to zero.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_nw_sel_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin search: first set request at or after ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_picker import mux_pkg::*; #(
    parameter int NCH  = 4,
    parameter int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            any_grant
);

    // Walk offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NCH;
            if (req[idx]) begin
                grant     = SELW'(idx);
                any_grant = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_nw_sel.sv
// ============================================================================
// Module  : mux_nw_sel
// Brief   : N-channel registered mux with manual or round-robin selection and
//           valid/ready handshaking on both sides.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_nw_sel import mux_pkg::*; #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] mux_in,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_accept;
    logic [SELW-1:0]  w_rr_grant;
    logic             w_rr_any;
    logic             w_man_any;
    logic [SELW-1:0]  w_grant;
    logic             w_has_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_word;
    logic [NCH-1:0]   w_ready;

    rr_picker #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_picker (
        .req       (in_valid),
        .ptr       (r_ptr),
        .grant     (w_rr_grant),
        .any_grant (w_rr_any)
    );

    assign w_accept = !r_out_valid || out_ready;

    // Compare against each legal index so an out-of-range sel never indexes.
    always_comb begin
        w_man_any = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                w_man_any = 1'b1;
            end
        end
    end

    assign w_grant     = (mode == MODE_RR) ? w_rr_grant : sel;
    assign w_has_grant = (mode == MODE_RR) ? w_rr_any   : w_man_any;
    assign w_xfer      = !rst && w_accept && w_has_grant;

    always_comb begin
        w_ready = '0;
        w_word  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SELW'(i)) begin
                w_ready[i] = w_xfer;
                w_word     = mux_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_word;
            r_out_ch    <= w_grant;
            r_out_valid <= 1'b1;
            if (mode == MODE_RR) begin
                r_ptr <= (w_grant == SELW'(NCH - 1)) ? '0 : w_grant + SELW'(1);
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_nw_sel.sv
// ============================================================================
// Module  : tb_mux_nw_sel
// Brief   : Directed self-checking bench for mux_nw_sel (NCH=4, WIDTH=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_nw_sel;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] mux_in;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic                 mode;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mux_nw_sel #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mux_in    (mux_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        mux_in    = {8'h3C, 8'hA5, 8'h22, 8'h11};
        tick();
        tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data",  out_data,  0);
        chk("reset_out_ch",    out_ch,    0);
        chk("reset_in_ready",  in_ready,  0);

        // Manual select of channel 2
        rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        chk("man_in_ready", in_ready, 4'b0100);
        tick();
        chk("man_out_data",  out_data,  8'hA5);
        chk("man_out_ch",    out_ch,    2);
        chk("man_out_valid", out_valid, 1);
        in_valid = 4'b0000;
        #1;
        chk("man_idle_ready", in_ready, 0);
        tick();
        chk("drain_out_valid", out_valid, 0);
        chk("drain_hold_data", out_data,  8'hA5);
        chk("drain_hold_ch",   out_ch,    2);

        // Round-robin over all requesters, no bubbles
        mode = 1'b1; in_valid = 4'b1111;
        #1;
        chk("rr_first_ready", in_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_seq_ch",    out_ch,    k % 4);
            chk("rr_seq_valid", out_valid, 1);
            chk("rr_seq_data",  out_data,  (k % 4 == 0) ? 8'h11 : (k % 4 == 1) ? 8'h22 :
                                           (k % 4 == 2) ? 8'hA5 : 8'h3C);
        end
        chk("rr_ptr_after_wrap", in_ready, 4'b0010);
        in_valid = 4'b0000;
        tick();
        chk("rr_drain_valid", out_valid, 0);

        // Backpressure on a held word
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b0;
        #1;
        chk("bp_first_ready", in_ready, 4'b1000);
        tick();
        mux_in[31:24] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_out_data",  out_data,  8'h3C);
            chk("bp_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1; sel = 2'd1; in_valid = 4'b0010;
        #1;
        chk("bp_release_ready", in_ready, 4'b0010);
        tick();
        chk("bp_next_data", out_data, 8'h22);
        chk("bp_next_ch",   out_ch,   1);
        in_valid = 4'b0000;
        tick();
        chk("bp_drain_valid", out_valid, 0);

        // Round-robin skip: move ptr to 3, then request only channel 1
        mode = 1'b1; in_valid = 4'b0100;
        #1;
        chk("skip_setup_ready", in_ready, 4'b0100);
        tick();
        in_valid = 4'b0010;
        #1;
        chk("skip_ready", in_ready, 4'b0010);
        tick();
        chk("skip_out_ch",   out_ch,   1);
        chk("skip_out_data", out_data, 8'h22);
        in_valid = 4'b0110;
        #1;
        chk("skip_ptr_is_2", in_ready, 4'b0100);
        tick();
        chk("skip_ptr2_ch", out_ch, 2);

        // Manual select of an idle channel never grants
        mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
        #1;
        chk("man_nogrant_ready", in_ready, 0);
        tick();
        chk("man_nogrant_valid", out_valid, 0);
        chk("man_nogrant_ch",    out_ch,    2);

        // Reset while a word is held
        mode = 1'b1; in_valid = 4'b1000; out_ready = 1'b0;
        #1;
        chk("mid_load_ready", in_ready, 4'b1000);
        tick();
        chk("mid_held_data", out_data, 8'h5A);
        rst = 1'b1; out_ready = 1'b1;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data",  out_data,  0);
        chk("mid_rst_ch",    out_ch,    0);
        rst = 1'b0; in_valid = 4'b1111;
        #1;
        chk("post_rst_ready", in_ready, 4'b0001);
        tick();
        chk("post_rst_ch",   out_ch,   0);
        chk("post_rst_data", out_data, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_nw_sel.md
MUX_NW_SEL -- requirements
Module: mux_nw_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per channel.
REQ-002 SHALL have parameter NCH, default 4: channel count, >=2.
REQ-003 SHALL derive local constant SELW = max(1, clog2(NCH)).
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mux_in  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  NCH  per-channel data-valid.
REQ-008 SHALL have port in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
REQ-009 SHALL have port sel  input  SELW  channel select, used in manual mode.
REQ-010 SHALL have port mode  input  1  0 = manual select, 1 = round-robin.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-012 SHALL have port out_ch  output  SELW  source channel of out_data.
REQ-013 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL define accept = !out_valid || out_ready; captures occur only when accept is 1.
REQ-016 Manual mode: grant = sel iff sel < NCH and in_valid[sel]; otherwise no grant.
REQ-017 Round-robin mode: grant = first i with in_valid[i], searching ptr, ptr+1, ... mod NCH; no grant if in_valid = 0.
REQ-018 in_ready[g] SHALL be 1 in exactly the cycles where accept and a grant g exist (combinational); all other bits 0.
REQ-019 On a transfer (in_valid[g] && in_ready[g]), the next edge SHALL load out_data = channel g, out_ch = g, out_valid = 1 (latency 1 cycle).
REQ-020 On out_valid && out_ready with no new transfer, the next edge SHALL clear out_valid; out_data and out_ch SHALL hold.
REQ-021 On out_valid && !out_ready, out_data, out_ch and out_valid SHALL stay stable (no overwrite).
REQ-022 Simultaneous drain and capture SHALL sustain one word per cycle with no bubble.
REQ-023 ptr SHALL become (g+1) mod NCH after each round-robin transfer; wrap NCH-1 -> 0. Manual transfers and idle cycles SHALL leave ptr unchanged.
REQ-024 mode and sel SHALL be sampled combinationally each cycle; a mode change SHALL affect only the next grant and SHALL never alter a held word.
REQ-025 Non-power-of-two NCH SHALL be supported; sel >= NCH SHALL never grant or index out of range.

Reset
REQ-026 While rst = 1 at an edge: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
REQ-027 in_ready SHALL be all-zero in any cycle where rst = 1.
REQ-028 Reset during a held word SHALL discard it; no transfer SHALL complete in the reset cycle.

Structure
REQ-029 Package mux_pkg SHALL hold MODE_MANUAL = 0, MODE_RR = 1 and the clog2 helper.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_picker (inputs req[NCH], ptr; outputs grant index and any_grant).
REQ-031 Top level SHALL contain only the output register, ptr register and grant/handshake logic.

Verification (NCH=4, WIDTH=8)
REQ-032 Manual mode: mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100 in the same cycle; next cycle out_data=A5, out_ch=2, out_valid=1.
REQ-033 Round-robin mode: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-034 Backpressure: out_ready=0 with word 8'h3C held for 3 cycles -> in_ready=0 and out_data=3C throughout; after out_ready=1, the next word is captured the same cycle.
REQ-035 Round-robin skip: ptr=3, in_valid=4'b0010 -> grant channel 1 and ptr becomes 2. Manual mode with sel=3 and in_valid[3]=0 -> no grant and out_valid falls after drain.
REQ-036 Reset mid-operation: rst=1 while out_valid=1 -> next cycle out_valid=0, out_data=00, out_ch=0; after release, the first round-robin grant starts at channel 0.
